// File: rtl/divider_pkg.sv
// Shared constants, FSM state type and magnitude helpers for the signed divider.
package divider_pkg;

  localparam int unsigned WIDTH = 64;
  localparam int unsigned CNT_W = 7;

  localparam logic [CNT_W-1:0] ITERS = CNT_W'(WIDTH);
  localparam logic [WIDTH-1:0] SMIN  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_t;

  // Unsigned magnitude; SMIN maps to 2^(WIDTH-1), which still fits in WIDTH bits.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? WIDTH'(-x) : x;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic neg);
    return neg ? WIDTH'(-x) : x;
  endfunction

endpackage

// File: rtl/divider_iter.sv
// One restoring shift-subtract step on unsigned magnitudes.
module divider_iter
  import divider_pkg::*;
(
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] divisor_ext;

  always_comb begin
    shifted     = {rem, quo[WIDTH-1]};
    divisor_ext = {2'b00, divisor};
    if (shifted >= divisor_ext) begin
      rem_next = (WIDTH+1)'(shifted - divisor_ext);
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = (WIDTH+1)'(shifted);
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/divider.sv
// Multi-cycle signed divider, C semantics (truncating quotient, remainder follows dividend).
module divider
  import divider_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] r,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   div_q, div_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic               dz_q, dz_d;
  logic               min_neg1_q, min_neg1_d;
  logic [WIDTH-1:0]   quotient_q, quotient_d;
  logic [WIDTH-1:0]   r_q, r_d;
  logic               overflow_q, overflow_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WIDTH:0]     rem_nx;
  logic [WIDTH-1:0]   quo_nx;

  divider_iter u_iter (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (div_q),
    .rem_next (rem_nx),
    .quo_next (quo_nx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      div_q      <= '0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      dz_q       <= 1'b0;
      min_neg1_q <= 1'b0;
      quotient_q <= '0;
      r_q        <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      div_q      <= div_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      dz_q       <= dz_d;
      min_neg1_q <= min_neg1_d;
      quotient_q <= quotient_d;
      r_q        <= r_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // RUN spends one extra cycle at cnt==ITERS so done lands 66 edges after accept.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    div_d      = div_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    dz_d       = dz_q;
    min_neg1_d = min_neg1_q;
    quotient_d = quotient_q;
    r_d        = r_q;
    overflow_d = overflow_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = RUN;
          cnt_d      = '0;
          rem_d      = '0;
          quo_d      = mag(a);
          div_d      = mag(b);
          sign_a_d   = a[WIDTH-1];
          sign_b_d   = b[WIDTH-1];
          dz_d       = (b == '0);
          min_neg1_d = (a == SMIN) && (b == '1);
        end
      end
      RUN: begin
        if (cnt_q == ITERS) begin
          state_d = FIX;
        end else begin
          rem_d = rem_nx;
          quo_d = quo_nx;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      FIX: begin
        quotient_d = dz_q ? '1 : cond_neg(quo_q, sign_a_q ^ sign_b_q);
        r_d        = cond_neg(rem_q[WIDTH-1:0], sign_a_q);
        overflow_d = dz_q | min_neg1_q;
        state_d    = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN) || (state_d == FIX);
    done_d = (state_d == DONE);
  end

  assign quotient = quotient_q;
  assign r        = r_q;
  assign overflow = overflow_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed, special, control and random operand pairs.
module tb_divider;

  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
  localparam int          LAT   = 66;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic [63:0] quotient;
  logic [63:0] r;
  logic        overflow;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  divider dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .quotient (quotient),
    .r        (r),
    .overflow (overflow),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // C-semantics reference with the two flagged exceptions.
  function automatic void ref_div(input logic [63:0] av, input logic [63:0] bv,
                                  output logic [63:0] q, output logic [63:0] rr, output logic o);
    if (bv == 64'd0) begin
      q = '1; rr = av; o = 1'b1;
    end else if (av == MIN64 && bv == '1) begin
      q = MIN64; rr = '0; o = 1'b1;
    end else begin
      q = 64'($signed(av) / $signed(bv));
      rr = 64'($signed(av) % $signed(bv));
      o = 1'b0;
    end
  endfunction

  // Launch one operation from idle; returns results and edges from accept to done.
  task automatic do_op(input logic [63:0] av, input logic [63:0] bv,
                       output logic [63:0] q, output logic [63:0] rr, output logic o,
                       output int lat);
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    lat = 0;
    while (done !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    q = quotient; rr = r; o = overflow;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({quotient, r, overflow, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset: q=%h r=%h ovf=%b busy=%b done=%b, required all 0",
               quotient, r, overflow, busy, done);
    end
  endtask

  task automatic test_latency();
    int lat;
    @(negedge clk);
    a = 64'd78; b = 64'd97; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL busy_after_accept: busy=%b required 1", busy);
    end
    lat = 0;
    while (done !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== LAT || busy !== 1'b0) begin
      errors++; $display("FAIL latency_78_97: lat=%0d busy=%b, required %0d and 0", lat, busy, LAT);
    end
    checks++;
    if (quotient !== 64'd0 || r !== 64'd78 || overflow !== 1'b0) begin
      errors++; $display("FAIL div_78_97: q=%0d r=%0d ovf=%b, required 0 78 0",
                         $signed(quotient), $signed(r), overflow);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL done_pulse: done=%b one cycle later, required 0", done);
    end
  endtask

  task automatic test_directed();
    logic [63:0] ta [10];
    logic [63:0] tb [10];
    logic [63:0] eq [10];
    logic [63:0] er [10];
    logic        eo [10];
    logic [63:0] q, rr;
    logic o;
    int lat;
    ta[0] = 64'd2504532;   tb[0] = 64'd945327;  eq[0] = 64'd2;   er[0] = 64'd613878;  eo[0] = 0;
    ta[1] = -64'd45;       tb[1] = 64'd65437;   eq[1] = 64'd0;   er[1] = -64'd45;     eo[1] = 0;
    ta[2] = -64'd24878735; tb[2] = -64'd879357; eq[2] = 64'd28;  er[2] = -64'd256739; eo[2] = 0;
    ta[3] = -64'd20;       tb[3] = -64'd5;      eq[3] = 64'd4;   er[3] = 64'd0;       eo[3] = 0;
    ta[4] = 64'd20;        tb[4] = -64'd5;      eq[4] = -64'd4;  er[4] = 64'd0;       eo[4] = 0;
    ta[5] = -64'd20;       tb[5] = 64'd5;       eq[5] = -64'd4;  er[5] = 64'd0;       eo[5] = 0;
    ta[6] = 64'd20;        tb[6] = 64'd5;       eq[6] = 64'd4;   er[6] = 64'd0;       eo[6] = 0;
    ta[7] = 64'd7;         tb[7] = 64'd0;       eq[7] = '1;      er[7] = 64'd7;       eo[7] = 1;
    ta[8] = MIN64;         tb[8] = '1;          eq[8] = MIN64;   er[8] = 64'd0;       eo[8] = 1;
    ta[9] = 64'd0;         tb[9] = -64'd13;     eq[9] = 64'd0;   er[9] = 64'd0;       eo[9] = 0;
    for (int i = 0; i < 10; i++) begin
      do_op(ta[i], tb[i], q, rr, o, lat);
      checks++;
      if (q !== eq[i] || rr !== er[i] || o !== eo[i] || lat !== LAT) begin
        errors++;
        $display("FAIL directed[%0d] %0d/%0d: got q=%0d r=%0d ovf=%b lat=%0d, required q=%0d r=%0d ovf=%b lat=%0d",
                 i, $signed(ta[i]), $signed(tb[i]), $signed(q), $signed(rr), o, lat,
                 $signed(eq[i]), $signed(er[i]), eo[i], LAT);
      end
    end
  endtask

  task automatic test_busy_ignore();
    logic [63:0] prev_q;
    int lat;
    prev_q = quotient;
    @(negedge clk);
    a = 64'd100; b = 64'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (quotient !== prev_q) begin
      errors++; $display("FAIL hold_during_run: q=%h required %h", quotient, prev_q);
    end
    lat = 0;
    repeat (10) begin @(negedge clk); lat++; end
    a = 64'd5; b = 64'd1; start = 1'b1;
    @(negedge clk); lat++;
    start = 1'b0;
    while (done !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (quotient !== 64'd14 || r !== 64'd2 || overflow !== 1'b0 || lat !== LAT) begin
      errors++; $display("FAIL start_while_busy: q=%0d r=%0d ovf=%b lat=%0d, required 14 2 0 %0d",
                         $signed(quotient), $signed(r), overflow, lat, LAT);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] q, rr, eq, er;
    logic o, eo;
    int lat;
    do_op(64'd1000, 64'd33, q, rr, o, lat);
    checks++;
    if (q !== 64'd30 || rr !== 64'd10 || lat !== LAT) begin
      errors++; $display("FAIL b2b_first: q=%0d r=%0d lat=%0d, required 30 10 %0d", q, rr, lat, LAT);
    end
    a = -64'd999; b = 64'd10; start = 1'b1;
    ref_div(-64'd999, 64'd10, eq, er, eo);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL start_in_done: busy=%b done=%b, required 0 0", busy, done);
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL start_after_done: busy=%b required 1", busy);
    end
    lat = 0;
    while (done !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (quotient !== eq || r !== er || overflow !== eo || lat !== LAT) begin
      errors++; $display("FAIL b2b_second: q=%0d r=%0d ovf=%b lat=%0d, required %0d %0d %b %0d",
                         $signed(quotient), $signed(r), overflow, lat,
                         $signed(eq), $signed(er), eo, LAT);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [63:0] q, rr;
    logic o, seen;
    int lat;
    @(negedge clk);
    a = 64'd123456789; b = 64'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({quotient, r, overflow, busy, done} !== '0) begin
      errors++; $display("FAIL reset_mid_run: q=%h r=%h ovf=%b busy=%b done=%b, required all 0",
                         quotient, r, overflow, busy, done);
    end
    seen = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL abort_mid_run: activity after reset=%b, required 0", seen);
    end
    do_op(64'd50, -64'd7, q, rr, o, lat);
    checks++;
    if (q !== -64'd7 || rr !== 64'd1 || o !== 1'b0 || lat !== LAT) begin
      errors++; $display("FAIL after_reset_op: q=%0d r=%0d ovf=%b lat=%0d, required -7 1 0 %0d",
                         $signed(q), $signed(rr), o, lat, LAT);
    end
  endtask

  task automatic test_random();
    logic [63:0] av, bv, q, rr, eq, er;
    logic o, eo;
    int lat;
    for (int i = 0; i < 40; i++) begin
      av = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: bv = 64'($signed($urandom_range(0, 40)) - 20);
        1: bv = {{32{$urandom_range(0, 1) == 1}}, $urandom};
        2: begin av = MIN64; bv = {$urandom, $urandom}; end
        3: av = 64'($signed($urandom_range(0, 2000)) - 1000);
        default: bv = {$urandom, $urandom};
      endcase
      if (i == 0) bv = 64'd0;
      if (i == 1) begin av = MIN64; bv = '1; end
      if (i == 2) begin av = MIN64; bv = 64'd0; end
      ref_div(av, bv, eq, er, eo);
      do_op(av, bv, q, rr, o, lat);
      checks++;
      if (q !== eq || rr !== er || o !== eo || lat !== LAT) begin
        errors++;
        $display("FAIL random[%0d] %h/%h: got q=%h r=%h ovf=%b lat=%0d, required q=%h r=%h ovf=%b lat=%0d",
                 i, av, bv, q, rr, o, lat, eq, er, eo, LAT);
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_directed();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
